hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It sits beside the ID stage and decides three things each cycle: whether IF/ID/EX advance, whether bubbles or flushes are inserted, and which EX operand source is selected. It detects load-use and branch hazards and sequences multi-cycle multiply/divide (MDU) occupancy of EX. It also registers the EX operand forwarding selects for the instruction entering EX.

---
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX/MEM hazard inputs and the stage
// control, bubble/flush and forwarding-select outputs.
interface hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_is_mdu;
    logic [4:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic       branch_taken;

    logic       pc_en;
    logic       ifid_en;
    logic       idex_en;
    logic       idex_bubble;
    logic       exmem_bubble;
    logic       ifid_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mdu_busy;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_is_mdu,
               ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite, branch_taken,
        input  pc_en, ifid_en, idex_en, idex_bubble, exmem_bubble, ifid_flush,
               fwd_a, fwd_b, mdu_busy
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_is_mdu,
               ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite, branch_taken,
        output pc_en, ifid_en, idex_en, idex_bubble, exmem_bubble, ifid_flush,
               fwd_a, fwd_b, mdu_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS hazard/sequencing controller: load-use, branch flush, MDU occupancy
// and registered EX forwarding selects. Define HAZ_STATS_EN to add stall_count.
module hazard_ctrl #(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    hazard_ctrl_if.slave hif
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_e;

    localparam logic [3:0] CNT_INIT  = 4'(MDU_LAT - 1);
    localparam logic       MDU_MULTI = (MDU_LAT > 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;

    logic load_use;
    logic pc_en, ifid_en, idex_en, idex_bubble, exmem_bubble, ifid_flush;

    // Newer producer (EX) wins over MEM; rd==0 is never a real write.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] ex_rd,
                                           input logic       ex_wr,
                                           input logic [4:0] mem_rd,
                                           input logic       mem_wr);
        if (ex_wr && ex_rd != 5'd0 && ex_rd == src)
            return 2'b01;
        else if (mem_wr && mem_rd != 5'd0 && mem_rd == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign load_use = hif.id_valid && hif.ex_memread && (hif.ex_rd != 5'd0) &&
                      ((hif.ex_rd == hif.id_rs) ||
                       (hif.id_uses_rt && hif.ex_rd == hif.id_rt));

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        ifid_flush   = 1'b0;
        fwd_a_d      = fwd_a_q;
        fwd_b_d      = fwd_b_q;

        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (hif.branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (hif.id_valid && hif.id_is_mdu && MDU_MULTI) begin
                        state_d = MDU_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
                MDU_BUSY: begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_bubble = 1'b1;
                    cnt_d        = cnt_q - 4'd1;
                    // <= 1 rather than == 1 so a corrupted count cannot wedge EX.
                    if (cnt_q <= 4'd1)
                        state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end

        if (idex_en) begin
            if (idex_bubble) begin
                fwd_a_d = 2'b00;
                fwd_b_d = 2'b00;
            end else begin
                fwd_a_d = fwd_sel(hif.id_rs, hif.ex_rd, hif.ex_regwrite, hif.mem_rd, hif.mem_regwrite);
                fwd_b_d = fwd_sel(hif.id_rt, hif.ex_rd, hif.ex_regwrite, hif.mem_rd, hif.mem_regwrite);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign hif.pc_en        = pc_en;
    assign hif.ifid_en      = ifid_en;
    assign hif.idex_en      = idex_en;
    assign hif.idex_bubble  = idex_bubble;
    assign hif.exmem_bubble = exmem_bubble;
    assign hif.ifid_flush   = ifid_flush;
    assign hif.fwd_a        = fwd_a_q;
    assign hif.fwd_b        = fwd_b_q;
    assign hif.mdu_busy     = (state_q == MDU_BUSY) && !reset;

`ifdef HAZ_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;

    // Free-running wrap at 2^32 is intended.
    assign stall_count_d = pc_en ? stall_count_q : stall_count_q + 32'd1;

    always_ff @(posedge clk) begin
        if (reset)
            stall_count_q <= 32'd0;
        else
            stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then randomized traffic,
// all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned MDU_LAT = 4;

    logic clk;
    logic reset;
    hazard_ctrl_if hif();

`ifdef HAZ_STATS_EN
    logic [31:0] stall_count;
`endif

    hazard_ctrl #(.MDU_LAT(MDU_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
`ifdef HAZ_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: remaining MDU stall cycles, pending EX selects, stall total.
    int          m_busy_left = 0;
    logic [1:0]  m_fa = 2'b00;
    logic [1:0]  m_fb = 2'b00;
    logic [31:0] m_stall = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        hif.id_valid     = 1'b0;
        hif.id_rs        = 5'd0;
        hif.id_rt        = 5'd0;
        hif.id_uses_rt   = 1'b0;
        hif.id_is_mdu    = 1'b0;
        hif.ex_rd        = 5'd0;
        hif.ex_regwrite  = 1'b0;
        hif.ex_memread   = 1'b0;
        hif.mem_rd       = 5'd0;
        hif.mem_regwrite = 1'b0;
        hif.branch_taken = 1'b0;
    endtask

    function automatic logic [1:0] expect_src(input logic [4:0] r);
        if (r == 5'd0) return 2'b00;
        if (hif.ex_regwrite && hif.ex_rd == r) return 2'b01;
        if (hif.mem_regwrite && hif.mem_rd == r) return 2'b10;
        return 2'b00;
    endfunction

    // Called just after a falling edge with inputs applied; checks this cycle,
    // advances the model across the next rising edge, returns at the next falling edge.
    task automatic step();
        logic lu, e_pc, e_ifid, e_idex, e_ib, e_eb, e_fl, e_busy, start;
        #1;
        lu = hif.id_valid && hif.ex_memread && hif.ex_rd != 5'd0 &&
             (hif.ex_rd == hif.id_rs || (hif.id_uses_rt && hif.ex_rd == hif.id_rt));
        e_pc = 1; e_ifid = 1; e_idex = 1; e_ib = 0; e_eb = 0; e_fl = 0;
        e_busy = !reset && m_busy_left > 0;
        start  = 0;
        if (!reset) begin
            if (m_busy_left > 0) begin
                e_pc = 0; e_ifid = 0; e_idex = 0; e_eb = 1;
            end else if (hif.branch_taken) begin
                e_fl = 1; e_ib = 1;
            end else if (lu) begin
                e_pc = 0; e_ifid = 0; e_ib = 1;
            end else begin
                start = hif.id_valid && hif.id_is_mdu && MDU_LAT > 1;
            end
        end

        check("pc_en",        hif.pc_en,        e_pc);
        check("ifid_en",      hif.ifid_en,      e_ifid);
        check("idex_en",      hif.idex_en,      e_idex);
        check("idex_bubble",  hif.idex_bubble,  e_ib);
        check("exmem_bubble", hif.exmem_bubble, e_eb);
        check("ifid_flush",   hif.ifid_flush,   e_fl);
        check("mdu_busy",     hif.mdu_busy,     e_busy);
        check("fwd_a",        hif.fwd_a,        m_fa);
        check("fwd_b",        hif.fwd_b,        m_fb);
`ifdef HAZ_STATS_EN
        check("stall_count",  stall_count,      m_stall);
`endif

        if (reset) begin
            m_busy_left = 0;
            m_fa = 2'b00;
            m_fb = 2'b00;
            m_stall = 32'd0;
        end else begin
            if (!e_pc) m_stall = m_stall + 32'd1;
            if (e_ib) begin
                m_fa = 2'b00;
                m_fb = 2'b00;
            end else if (e_idex) begin
                m_fa = expect_src(hif.id_rs);
                m_fb = expect_src(hif.id_rt);
            end
            if (m_busy_left > 0) m_busy_left--;
            else if (start) m_busy_left = MDU_LAT - 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        reset = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);

        // Reset held two cycles with a load-use pattern present.
        hif.id_valid = 1; hif.ex_memread = 1; hif.ex_rd = 5'd3; hif.id_rs = 5'd3;
        #1;
        check("rst_pc_en", hif.pc_en, 1'b1);
        check("rst_bubble", hif.idex_bubble, 1'b0);
        step();
        step();
        check("rst_fwd_a", hif.fwd_a, 2'b00);
        check("rst_fwd_b", hif.fwd_b, 2'b00);
        check("rst_mdu_busy", hif.mdu_busy, 1'b0);
        reset = 1'b0;

        // Branch overrides a simultaneous load-use.
        hif.branch_taken = 1;
        #1;
        check("br_flush", hif.ifid_flush, 1'b1);
        check("br_bubble", hif.idex_bubble, 1'b1);
        check("br_pc_en", hif.pc_en, 1'b1);
        step();
`ifdef HAZ_STATS_EN
        check("br_stall_count", stall_count, 32'd0);
`endif
        hif.branch_taken = 0;
        step();
`ifdef HAZ_STATS_EN
        check("lu_stall_count", stall_count, 32'd1);
`endif

        // ALU chain forwarding.
        idle();
        hif.id_valid = 1; hif.ex_regwrite = 1; hif.ex_rd = 5'd5; hif.id_rs = 5'd5; hif.id_rt = 5'd9;
        step();
        check("alu_fwd_a", hif.fwd_a, 2'b01);
        check("alu_fwd_b", hif.fwd_b, 2'b00);
        hif.ex_rd = 5'd0; hif.id_rs = 5'd0;
        step();
        check("r0_fwd_a", hif.fwd_a, 2'b00);

        // EX beats MEM, then MEM alone.
        idle();
        hif.id_valid = 1; hif.ex_regwrite = 1; hif.mem_regwrite = 1;
        hif.ex_rd = 5'd7; hif.mem_rd = 5'd7; hif.id_rs = 5'd7;
        step();
        check("prio_fwd_a", hif.fwd_a, 2'b01);
        hif.ex_regwrite = 0;
        step();
        check("mem_fwd_a", hif.fwd_a, 2'b10);

        // Load-use on rt: one stall, then MEM forward.
        idle();
        hif.id_valid = 1; hif.ex_memread = 1; hif.ex_regwrite = 1; hif.ex_rd = 5'd3;
        hif.id_rt = 5'd3; hif.id_uses_rt = 1; hif.id_rs = 5'd1;
        #1;
        check("lu_pc_en", hif.pc_en, 1'b0);
        check("lu_ifid_en", hif.ifid_en, 1'b0);
        check("lu_bubble", hif.idex_bubble, 1'b1);
        step();
        check("lu_fwd_b", hif.fwd_b, 2'b00);
        hif.ex_memread = 0; hif.ex_regwrite = 0; hif.ex_rd = 5'd0;
        hif.mem_rd = 5'd3; hif.mem_regwrite = 1;
        #1;
        check("lu_after_pc_en", hif.pc_en, 1'b1);
        step();
        check("lu_after_fwd_b", hif.fwd_b, 2'b10);

        // Same load but rt not read: no stall.
        idle();
        hif.id_valid = 1; hif.ex_memread = 1; hif.ex_regwrite = 1; hif.ex_rd = 5'd3;
        hif.id_rt = 5'd3; hif.id_uses_rt = 0; hif.id_rs = 5'd1;
        #1;
        check("nolu_pc_en", hif.pc_en, 1'b1);
        check("nolu_bubble", hif.idex_bubble, 1'b0);
        step();

        // MDU occupancy length.
        idle();
        hif.id_valid = 1; hif.id_is_mdu = 1;
        step();
        idle();
        busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (hif.mdu_busy) busy_cycles++;
            step();
        end
        check("mdu_busy_cycles", busy_cycles, MDU_LAT - 1);

        // Reset in the second busy cycle clears the stall.
        hif.id_valid = 1; hif.id_is_mdu = 1;
        step();
        idle();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("mdu_rst_busy", hif.mdu_busy, 1'b0);
        check("mdu_rst_pc_en", hif.pc_en, 1'b1);
        step();

        // Randomized traffic over a small register range to provoke matches.
        for (int n = 0; n < 800; n++) begin
            reset            = ($urandom_range(0, 39) == 0);
            hif.id_valid     = ($urandom_range(0, 7) != 0);
            hif.id_rs        = 5'($urandom_range(0, 3));
            hif.id_rt        = 5'($urandom_range(0, 3));
            hif.id_uses_rt   = 1'($urandom_range(0, 1));
            hif.id_is_mdu    = ($urandom_range(0, 5) == 0);
            hif.ex_rd        = 5'($urandom_range(0, 3));
            hif.ex_regwrite  = 1'($urandom_range(0, 1));
            hif.ex_memread   = ($urandom_range(0, 3) == 0);
            hif.mem_rd       = 5'($urandom_range(0, 3));
            hif.mem_regwrite = 1'($urandom_range(0, 1));
            hif.branch_taken = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
